// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory bus between instruction fetch (IF) and
// load/store (MEM). It accepts one request at a time, latches the winner's
// payload into the bus registers, holds the request until the bus accepts it,
// then routes the single response back to the owner.
//
// MEM has fixed priority over IF. Build option MEM_ARB_STARVE_GUARD_EN adds a
// 4-bit starvation counter. With it, IF is forced to win after STARVE_LIMIT
// consecutive MEM wins taken while IF was waiting.
//
// State table:
//   state    | meaning
//   IDLE     | no transaction; pick a winner, grant it, latch its payload
//   REQ_IF   | bus_req high with the IF payload; wait for bus_gnt
//   REQ_MEM  | bus_req high with the MEM payload; wait for bus_gnt
//   WAIT_IF  | bus accepted the IF read; forward bus_rvalid to IF
//   WAIT_MEM | bus accepted the MEM access; forward bus_rvalid to MEM
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_gnt,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,

  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,

  output logic                busy
);

  // The guard counter is 4 bits wide, so any limit outside 1..15 is a build error.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_IF,
    ST_REQ_MEM,
    ST_WAIT_IF,
    ST_WAIT_MEM
  } state_t;

  state_t state;
  state_t state_nxt;

  logic   pick_if;
  logic   pick_mem;
  logic   force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign force_if = if_req && (starve_cnt == LIMIT);

  // Count MEM wins taken over a waiting IF. Saturate at the limit, and clear on any IF win.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pick_if) begin
      starve_cnt <= '0;
    end else if (pick_mem && if_req && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Winner selection. Only IDLE can grant, and reset suppresses every grant.
  always_comb begin
    pick_if  = 1'b0;
    pick_mem = 1'b0;
    if ((state == ST_IDLE) && !rst) begin
      if (force_if) begin
        pick_if = 1'b1;
      end else if (mem_req) begin
        pick_mem = 1'b1;
      end else if (if_req) begin
        pick_if = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the combinational grant/response/bus_req outputs.
  always_comb begin
    state_nxt  = state;
    if_gnt     = 1'b0;
    mem_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    mem_rvalid = 1'b0;
    if_rdata   = '0;
    mem_rdata  = '0;
    bus_req    = 1'b0;

    case (state)
      ST_IDLE: begin
        if_gnt  = pick_if;
        mem_gnt = pick_mem;
        if (pick_mem) begin
          state_nxt = ST_REQ_MEM;
        end else if (pick_if) begin
          state_nxt = ST_REQ_IF;
        end
      end
      ST_REQ_IF: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_nxt = ST_WAIT_IF;
        end
      end
      ST_REQ_MEM: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_nxt = ST_WAIT_MEM;
        end
      end
      ST_WAIT_IF: begin
        if (bus_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = bus_rdata;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (bus_rvalid) begin
          mem_rvalid = 1'b1;
          mem_rdata  = bus_rdata;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Reset drops the bus request and any response in the same cycle, not at the next edge.
    if (rst) begin
      state_nxt  = ST_IDLE;
      if_gnt     = 1'b0;
      mem_gnt    = 1'b0;
      if_rvalid  = 1'b0;
      mem_rvalid = 1'b0;
      if_rdata   = '0;
      mem_rdata  = '0;
      bus_req    = 1'b0;
    end
  end

  // Latch the winner's payload at the grant edge. It is held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wmask <= '0;
    end else if (pick_mem) begin
      bus_we    <= mem_we;
      bus_addr  <= mem_addr;
      bus_wdata <= mem_wdata;
      bus_wmask <= mem_wmask;
    end else if (pick_if) begin
      bus_we    <= 1'b0;
      bus_addr  <= if_addr;
      bus_wdata <= '0;
      bus_wmask <= '0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-port memory bus between instruction fetch (IF) and load/store (MEM) requesters, replacing the dual-read memory port arrangement in the single-cycle core. It sits between `if_stage`/`mem_stage` and the memory model. It accepts one request at a time, latches the winner's payload, drives the bus until it is granted, and routes the single response back to the owner. MEM has priority by default, with an optional starvation guard for IF.

## Interface
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, data width; the byte-mask width is `DATA_W/8`.
- `STARVE_LIMIT`, 4, number of consecutive MEM wins while IF waits before IF is forced (guard build only); legal range 1–15.

Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.

- `clk` in 1 — clock.
- `rst` in 1 — synchronous active-high reset.
- `if_req` in 1 — IF read request.
- `if_addr` in ADDR_W — fetch address.
- `if_gnt` out 1 — IF request accepted this cycle.
- `if_rvalid` out 1 — IF read data valid.
- `if_rdata` out DATA_W — IF read data.
- `mem_req` in 1 — MEM request.
- `mem_we` in 1 — 1 = write, 0 = read.
- `mem_addr` in ADDR_W — data address.
- `mem_wdata` in DATA_W — write data.
- `mem_wmask` in DATA_W/8 — byte enables.
- `mem_gnt` out 1 — MEM request accepted this cycle.
- `mem_rvalid` out 1 — MEM response valid (read data or write acknowledge).
- `mem_rdata` out DATA_W — MEM read data.
- `bus_req` out 1 — bus request.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_wmask` out — registered payload of the owner.
- `bus_gnt` in 1 — bus accepted the request.
- `bus_rvalid` in 1 — bus response.
- `bus_rdata` in DATA_W — bus read data.
- `busy` out 1 — state is not IDLE.

## Operation
FSM states: IDLE, REQ_IF, REQ_MEM, WAIT_IF, WAIT_MEM.

- **IDLE**
  - Winner selection: MEM if `mem_req`, otherwise IF if `if_req`. In the guard build, IF wins when `if_req` is high and `starve_cnt == STARVE_LIMIT`.
  - The winner's `*_gnt` is asserted combinationally in this cycle.
  - The winner's payload is latched into the `bus_*` registers at the edge. For IF, `bus_we=0`, `bus_wmask=0` and `bus_wdata=0`.
  - Next state: REQ_IF or REQ_MEM.
- **REQ_x**
  - `bus_req=1` with the payload held stable.
  - Stay until `bus_gnt`, then go to WAIT_x.
  - Requester inputs are ignored; `*_gnt=0`.
- **WAIT_x**
  - `bus_req=0`.
  - On `bus_rvalid`: `x_rvalid=1` and `x_rdata=bus_rdata` combinationally in the same cycle, then return to IDLE.
  - The non-owner's `rvalid` stays 0.
- **Response outputs**
  - `if_rdata`/`mem_rdata` are forced to 0 whenever the matching `rvalid` is 0.
- **Starvation counter** (guard build only; 4 bits)
  - Increments on each MEM grant taken while `if_req=1`.
  - Saturates at `STARVE_LIMIT`.
  - Clears on every IF grant.
- **Boundary conditions**
  - `bus_rvalid` in IDLE or REQ_x is ignored and routed to no one.
  - `bus_gnt` outside REQ_x is ignored.
  - Simultaneous `if_req` and `mem_req` in IDLE: exactly one `*_gnt`, never both.
  - A requester that drops `req` before its `gnt` loses nothing; nothing was latched.
  - `rst` in any state:
    - Next state is IDLE and `starve_cnt=0`.
    - Any outstanding response is discarded.
    - The bus must be reset in the same cycle.

## Timing
- Reset values: `if_gnt`, `if_rvalid`, `mem_gnt`, `mem_rvalid`, `bus_req`, `bus_we` and `busy` are 0. `if_rdata`, `mem_rdata`, `bus_addr`, `bus_wdata` and `bus_wmask` are 0.
- `*_gnt` is combinational in IDLE; requesters must hold `req` and payload stable until `gnt`.
- Cycle timeline for the fastest transaction:

  | Cycle | Event |
  |---|---|
  | 0 | `req` sampled, `gnt` asserted |
  | 1 | `bus_req` high; earliest `bus_gnt` |
  | 2 | earliest `bus_rvalid`, giving `x_rvalid` |
  | 3 | IDLE; next grant possible |

- Minimum issue interval is 3 cycles per transaction.
- The bus must not assert `bus_rvalid` in the same cycle as `bus_gnt`; such an `rvalid` is ignored.
- Exactly one outstanding transaction at any time.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN`
  - **Defined:** the starvation counter is present, and IF is forced after `STARVE_LIMIT` consecutive MEM wins taken while `if_req` was high.
  - **Undefined:** strict MEM-over-IF fixed priority, and the counter logic is absent.

## Test plan
- **Single IF read.** Reset, then `if_req=1`, `if_addr=0x80000000`; bus grants in cycle 1 and returns `0x0000_0013_0000_0093` in cycle 2. Required: `if_gnt` in cycle 0, `bus_addr=0x80000000` with `bus_we=0`, `if_rvalid` with that data in cycle 2, `mem_rvalid=0`, and `busy` low in cycle 3.
- **Collision.** `if_req` and `mem_req` (`we=1`, `addr=0x80001000`, `wdata=0xDEADBEEF`, `wmask=0x0F`) rise together. Required: only `mem_gnt`; the bus carries the write payload; the write ack appears on `mem_rvalid`; `if_gnt` follows in the next IDLE cycle.
- **Bus grant stall.** `bus_gnt` is held low for 5 cycles in REQ_MEM. Required: `bus_req` and payload remain stable for all 5 cycles, and no `*_gnt` is issued meanwhile.
- **Spurious and mid-transaction events.**
  - `bus_rvalid` pulsed in IDLE: no `*_rvalid`.
  - `rst` asserted in WAIT_IF: the state is IDLE at the next edge, and a late `bus_rvalid` is dropped.
- **Starvation guard.** With `MEM_ARB_STARVE_GUARD_EN` and `STARVE_LIMIT=4`, `mem_req` and `if_req` are held high continuously. Required: the grant sequence is M,M,M,M,I,M,M,M,M,I…; without the macro it is all M.
